// File: rtl/hub75_pkg.sv
// Shared HUB75 definitions: panel geometry, pixel layout, capture FSM states
// and the driver's state encodings.
package hub75_pkg;

  localparam int HUB75_COLS     = 64;
  localparam int HUB75_ROWPAIRS = 16;

  // Bit order matches the six data pins as shifted by the driver.
  typedef struct packed {
    logic r0;
    logic g0;
    logic b0;
    logic r1;
    logic g1;
    logic b1;
  } pixel6_t;

  typedef enum logic [1:0] {
    CAP_IDLE   = 2'd0,
    CAP_SHIFT  = 2'd1,
    CAP_COMMIT = 2'd2
  } capState_t;

  typedef enum logic [1:0] {
    DRV_BLANK = 2'd0,
    DRV_SHIFT = 2'd1,
    DRV_LATCH = 2'd2,
    DRV_SHOW  = 2'd3
  } drvState_t;

  function automatic logic [2:0] pixelHalf(input pixel6_t pix, input logic lower);
    pixelHalf = lower ? {pix.r1, pix.g1, pix.b1} : {pix.r0, pix.g0, pix.b0};
  endfunction

endpackage

// File: rtl/hub75_frame_store.sv
// Frame store: one line-wide write port, one registered 3-bit read port with
// upper/lower half select, and per-entry valid bits that mask stale data.
module hub75_frame_store
  import hub75_pkg::*;
#(
  parameter int COLS     = HUB75_COLS,
  parameter int ROWPAIRS = HUB75_ROWPAIRS,
  localparam int AW      = $clog2(ROWPAIRS),
  localparam int CW      = $clog2(COLS),
  localparam int LW      = COLS * 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wrEn,
  input  logic [AW-1:0] wrAddr,
  input  logic [LW-1:0] wrLine,
  input  logic [AW:0]   rdRow,
  input  logic [CW-1:0] rdCol,
  output logic [2:0]    rdRgb
);

  logic [LW-1:0]       mem [ROWPAIRS];
  logic [ROWPAIRS-1:0] validR;
  logic [AW-1:0]       rdEntry;
  logic                rdLower;
  logic [LW-1:0]       rdLine;
  pixel6_t             rdPix;

  assign rdLower = rdRow[AW];
  assign rdEntry = rdRow[AW-1:0];
  assign rdLine  = mem[rdEntry];
  assign rdPix   = pixel6_t'(rdLine[rdCol * 6 +: 6]);

  // Line storage; intentionally not reset, the valid bits hide old contents.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrAddr] <= wrLine;
    end
  end

  // Per-entry valid bits, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      validR <= '0;
    end else if (wrEn) begin
      validR[wrAddr] <= 1'b1;
    end
  end

  // Registered read; a same-cycle write is not visible until the next read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdRgb <= 3'b000;
    end else begin
      rdRgb <= validR[rdEntry] ? pixelHalf(rdPix, rdLower) : 3'b000;
    end
  end

endmodule

// File: rtl/hub75_capture.sv
// HUB75 receive-side capture: registers the panel pins, collects one line of
// samples per latch and commits complete lines into the frame store.
module hub75_capture
  import hub75_pkg::*;
#(
  parameter int COLS     = HUB75_COLS,
  parameter int ROWPAIRS = HUB75_ROWPAIRS,
  localparam int AW      = $clog2(ROWPAIRS),
  localparam int CW      = $clog2(COLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hub_a,
  input  logic          hub_b,
  input  logic          hub_c,
  input  logic          hub_d,
  input  logic          hub_r0,
  input  logic          hub_g0,
  input  logic          hub_b0,
  input  logic          hub_r1,
  input  logic          hub_g1,
  input  logic          hub_b1,
  input  logic          hub_oe,
  input  logic          hub_lat,
  input  logic [AW:0]   rd_row,
  input  logic [CW-1:0] rd_col,
  output logic [2:0]    rd_rgb,
  output logic          line_valid,
  output logic [AW-1:0] line_row,
  output logic          frame_done,
  output logic          short_err
);

  logic [AW-1:0]   addrPin;
  logic [AW-1:0]   addr_q;
  pixel6_t         pix_q;
  logic            oe_q;
  logic            lat_q;
  logic            latPrev;
  capState_t       state;
  capState_t       nextState;
  logic [CW:0]     sample_cnt;
  pixel6_t         lineReg [COLS];
  logic [COLS*6-1:0] lineFlat;
  logic            latRise;
  logic            doSample;
  logic            lineFull;
  logic            goCommit;
  logic            wrEn;

  assign addrPin  = AW'({hub_d, hub_c, hub_b, hub_a});
  assign latRise  = lat_q & ~latPrev;
  assign doSample = (state != CAP_COMMIT) & oe_q & ~lat_q;
  assign lineFull = (sample_cnt == (CW + 1)'(COLS));
  assign goCommit = (nextState == CAP_COMMIT);
  assign wrEn     = (state == CAP_COMMIT) & lineFull;

  // Input stage: one register on every panel pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      pix_q   <= '0;
      oe_q    <= 1'b0;
      lat_q   <= 1'b0;
      latPrev <= 1'b0;
    end else begin
      addr_q  <= addrPin;
      pix_q   <= pixel6_t'({hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1});
      oe_q    <= hub_oe;
      lat_q   <= hub_lat;
      latPrev <= lat_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CAP_IDLE;
    end else begin
      state <= nextState;
    end
  end

  // FSM next-state logic; a latch edge always wins over the OE level.
  always_comb begin
    nextState = state;
    case (state)
      CAP_IDLE: begin
        if (latRise) begin
          nextState = CAP_COMMIT;
        end else if (oe_q & ~lat_q) begin
          nextState = CAP_SHIFT;
        end else begin
          nextState = CAP_IDLE;
        end
      end
      CAP_SHIFT: begin
        if (latRise) begin
          nextState = CAP_COMMIT;
        end else if (~oe_q) begin
          nextState = CAP_IDLE;
        end else begin
          nextState = CAP_SHIFT;
        end
      end
      CAP_COMMIT: nextState = CAP_IDLE;
      default:    nextState = CAP_IDLE;
    endcase
  end

  // Sample counter, saturating at one full line and cleared by a commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt <= '0;
    end else if (state == CAP_COMMIT) begin
      sample_cnt <= '0;
    end else if (doSample && !lineFull) begin
      sample_cnt <= sample_cnt + (CW + 1)'(1);
    end
  end

  // Line shift register: newest sample enters at the top, oldest falls out of column 0.
  always_ff @(posedge clk) begin
    if (doSample) begin
      for (int i = 0; i < COLS - 1; i++) begin
        lineReg[i] <= lineReg[i+1];
      end
      lineReg[COLS-1] <= pix_q;
    end
  end

  // Flatten the line register for the full-line write port.
  always_comb begin
    lineFlat = '0;
    for (int i = 0; i < COLS; i++) begin
      lineFlat[i*6 +: 6] = lineReg[i];
    end
  end

  // Status pulses, registered on entry to COMMIT. The address pins seen here
  // are exactly what addr_q holds during the commit cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_valid <= 1'b0;
      frame_done <= 1'b0;
      short_err  <= 1'b0;
      line_row   <= '0;
    end else begin
      line_valid <= goCommit & lineFull;
      short_err  <= goCommit & ~lineFull;
      frame_done <= goCommit & lineFull & (addrPin == AW'(ROWPAIRS - 1));
      if (goCommit && lineFull) begin
        line_row <= addrPin;
      end
    end
  end

  hub75_frame_store #(
    .COLS     (COLS),
    .ROWPAIRS (ROWPAIRS)
  ) u_store (
    .clk    (clk),
    .rst    (rst),
    .wrEn   (wrEn),
    .wrAddr (addr_q),
    .wrLine (lineFlat),
    .rdRow  (rd_row),
    .rdCol  (rd_col),
    .rdRgb  (rd_rgb)
  );

endmodule

// File: tb/tb_hub75_capture.sv
// Scoreboard bench for hub75_capture: stimulus pushes expected commits and
// reads into queues, a negedge monitor pops and compares them.
module tb_hub75_capture;
  import hub75_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hub_a = 1'b0, hub_b = 1'b0, hub_c = 1'b0, hub_d = 1'b0;
  logic hub_r0 = 1'b0, hub_g0 = 1'b0, hub_b0 = 1'b0;
  logic hub_r1 = 1'b0, hub_g1 = 1'b0, hub_b1 = 1'b0;
  logic hub_oe = 1'b0, hub_lat = 1'b0;
  logic [4:0] rd_row = 5'd0;
  logic [5:0] rd_col = 6'd0;
  logic [2:0] rd_rgb;
  logic line_valid, frame_done, short_err;
  logic [3:0] line_row;

  hub75_capture dut (
    .clk(clk), .rst(rst),
    .hub_a(hub_a), .hub_b(hub_b), .hub_c(hub_c), .hub_d(hub_d),
    .hub_r0(hub_r0), .hub_g0(hub_g0), .hub_b0(hub_b0),
    .hub_r1(hub_r1), .hub_g1(hub_g1), .hub_b1(hub_b1),
    .hub_oe(hub_oe), .hub_lat(hub_lat),
    .rd_row(rd_row), .rd_col(rd_col), .rd_rgb(rd_rgb),
    .line_valid(line_valid), .line_row(line_row),
    .frame_done(frame_done), .short_err(short_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int         due;
    logic       isShort;
    logic       fd;
    logic [3:0] row;
  } evExp_t;

  typedef struct packed {
    int         due;
    logic       snap;
    logic [4:0] row;
    logic [5:0] col;
    logic [2:0] exp;
  } rdExp_t;

  evExp_t evQ[$];
  rdExp_t rdQ[$];
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int drainCnt = 0;
  logic stimDone = 1'b0;
  evExp_t evE;
  rdExp_t rdE;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [5:0] pixFor(input int mode, input int addr, input int c);
    logic [5:0] p;
    case (mode)
      0:       p = {c[0], 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      1:       p = 6'h3f;
      2:       p = (c == 0) ? 6'h3f : 6'h00;
      3:       p = 6'((addr * 7 + c * 3 + c / 4) % 64);
      default: p = 6'h00;
    endcase
    return p;
  endfunction

  task automatic setPhase(input drvState_t ph);
    case (ph)
      DRV_SHIFT: begin hub_oe = 1'b1; hub_lat = 1'b0; end
      DRV_LATCH: begin hub_oe = 1'b0; hub_lat = 1'b1; end
      default:   begin hub_oe = 1'b0; hub_lat = 1'b0; end
    endcase
  endtask

  task automatic driveSamples(input int addr, input int n, input int mode, input int pauseAt);
    logic [5:0] p;
    for (int i = 0; i < n; i++) begin
      if (i == pauseAt) begin
        repeat (3) begin
          @(posedge clk); #1;
          setPhase(DRV_BLANK);
        end
      end
      @(posedge clk); #1;
      {hub_d, hub_c, hub_b, hub_a} = 4'(addr);
      p = pixFor(mode, addr, i);
      {hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1} = p;
      setPhase(DRV_SHIFT);
    end
  endtask

  task automatic latchLine(input logic isShort, input int addr);
    evExp_t e;
    @(posedge clk); #1;
    setPhase(DRV_LATCH);
    e.due = cyc + 2;
    e.isShort = isShort;
    e.fd = !isShort && (addr == 15);
    e.row = isShort ? 4'd0 : 4'(addr);
    evQ.push_back(e);
    @(posedge clk); #1;
    setPhase(DRV_BLANK);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      setPhase(DRV_BLANK);
    end
  endtask

  task automatic driveLine(input int addr, input int n, input int mode, input int pauseAt);
    driveSamples(addr, n, mode, pauseAt);
    latchLine(n < 64, addr);
    idle(3);
  endtask

  task automatic doRead(input int row, input int col, input logic [2:0] exp);
    rdExp_t e;
    @(posedge clk); #1;
    rd_row = 5'(row);
    rd_col = 6'(col);
    e.due = cyc + 1;
    e.snap = 1'b0;
    e.row = 5'(row);
    e.col = 6'(col);
    e.exp = exp;
    rdQ.push_back(e);
  endtask

  task automatic snapshot();
    rdExp_t e;
    @(posedge clk); #1;
    e.due = cyc;
    e.snap = 1'b1;
    e.row = 5'd0;
    e.col = 6'd0;
    e.exp = 3'b000;
    rdQ.push_back(e);
  endtask

  // Monitor: compare every pulse and every scheduled read against the queues.
  always @(negedge clk) begin
    if (line_valid || short_err) begin
      total++;
      if (evQ.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse cyc=%0d valid=%0b short=%0b fd=%0b row=%0d", cyc, line_valid, short_err, frame_done, line_row);
      end else begin
        evE = evQ.pop_front();
        if ({line_valid, short_err, frame_done, (short_err ? 4'd0 : line_row), cyc} !=
            {~evE.isShort, evE.isShort, evE.fd, evE.row, evE.due}) begin
          bad++;
          $display("FAIL commit_event got valid=%0b short=%0b fd=%0b row=%0d cyc=%0d want valid=%0b short=%0b fd=%0b row=%0d cyc=%0d",
                   line_valid, short_err, frame_done, line_row, cyc, ~evE.isShort, evE.isShort, evE.fd, evE.row, evE.due);
        end
      end
    end
    while (evQ.size() > 0 && evQ[0].due < cyc) begin
      evE = evQ.pop_front();
      total++;
      bad++;
      $display("FAIL missing_event got none want short=%0b row=%0d at cyc=%0d", evE.isShort, evE.row, evE.due);
    end
    while (rdQ.size() > 0 && rdQ[0].due <= cyc) begin
      rdE = rdQ.pop_front();
      total++;
      if (rdE.snap) begin
        if ({rd_rgb, line_valid, line_row, frame_done, short_err} != 10'd0) begin
          bad++;
          $display("FAIL reset_state got rgb=%0b valid=%0b row=%0d fd=%0b short=%0b want all zero",
                   rd_rgb, line_valid, line_row, frame_done, short_err);
        end
      end else if (rd_rgb !== rdE.exp) begin
        bad++;
        $display("FAIL read(%0d,%0d) got %03b want %03b", rdE.row, rdE.col, rd_rgb, rdE.exp);
      end
    end
    if (stimDone) begin
      drainCnt++;
      if (evQ.size() == 0 && rdQ.size() == 0) begin
        total++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end else if (drainCnt > 50) begin
        total++;
        bad++;
        $display("FAIL drain got ev=%0d rd=%0d pending want 0", evQ.size(), rdQ.size());
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want test end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] p;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    snapshot();
    doRead(5, 10, 3'b000);

    // Address 3, r0 = column bit 0, g1 = 1; then a back-to-back short latch.
    driveSamples(3, 64, 0, -1);
    latchLine(1'b0, 3);
    latchLine(1'b1, 3);
    idle(3);
    doRead(3, 5, 3'b100);
    doRead(3, 4, 3'b000);
    doRead(19, 0, 3'b010);

    // Fill address 4 with ones, then overwrite with a 65-sample line whose first sample is dropped.
    driveLine(4, 64, 1, -1);
    doRead(4, 0, 3'b111);
    doRead(20, 63, 3'b111);
    driveLine(4, 65, 2, -1);
    doRead(4, 0, 3'b000);
    doRead(20, 0, 3'b000);
    doRead(4, 63, 3'b000);

    // Short line never commits.
    driveLine(9, 40, 3, -1);
    doRead(9, 0, 3'b000);
    doRead(25, 63, 3'b000);

    // Full frame; address 5 pauses OE mid-line.
    for (int a = 0; a < 16; a++) begin
      driveLine(a, 64, 3, (a == 5) ? 20 : -1);
    end
    for (int a = 0; a < 16; a++) begin
      for (int c = 0; c < 64; c++) begin
        p = pixFor(3, a, c);
        doRead(a, c, p[5:3]);
        doRead(a + 16, c, p[2:0]);
      end
    end

    // Reset mid-line, then a clean line at address 7.
    driveSamples(7, 30, 3, -1);
    @(posedge clk); #1;
    rst = 1'b1;
    setPhase(DRV_BLANK);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    snapshot();
    driveLine(7, 64, 3, -1);
    doRead(2, 0, 3'b000);
    doRead(18, 5, 3'b000);
    doRead(2, 63, 3'b000);
    for (int c = 0; c < 64; c += 21) begin
      p = pixFor(3, 7, c);
      doRead(7, c, p[5:3]);
      doRead(23, c, p[2:0]);
    end

    idle(4);
    stimDone = 1'b1;
  end

endmodule

// File: doc/hub75_capture.md
# hub75_capture

Receive-side counterpart of the HUB75 matrix driver. Samples the driver's row address, dual RGB data, OE and LAT lines on the system clock and rebuilds the 64x32 3-bit frame in an internal frame store. A random-access read port exposes the frame. Used as an on-chip loopback monitor and as the scoreboard model for panel-output verification.

## Interface
Parameters:
- COLS, 64, pixels shifted per row pair
- ROWPAIRS, 16, row pairs per frame; sets address width 4

Ports:
- clk  in  1  system clock; the same clock that drives the HUB75 driver
- rst  in  1  reset, asynchronous, active-high
- hub_a, hub_b, hub_c, hub_d  in  1 each  row-pair address {D,C,B,A}
- hub_r0, hub_g0, hub_b0  in  1 each  upper-half pixel (row r)
- hub_r1, hub_g1, hub_b1  in  1 each  lower-half pixel (row r+16)
- hub_oe  in  1  high = shift window
- hub_lat  in  1  latch strobe; rising edge commits the line
- rd_row  in  5  read row, 0..31
- rd_col  in  6  read column, 0..63
- rd_rgb  out  3  {R,G,B} at (rd_row, rd_col); 0 if that line was never committed
- line_valid  out  1  one-cycle pulse on each line commit
- line_row  out  4  row-pair address of the last commit
- frame_done  out  1  one-cycle pulse when row pair ROWPAIRS-1 is committed
- short_err  out  1  one-cycle pulse when a latch arrives with fewer than COLS samples

## Operation
- Input stage: all hub_* inputs are registered once. Every decision below uses the registered copies (suffix _q).
- FSM states: IDLE, SHIFT, COMMIT. Reset state is IDLE.
  - IDLE -> SHIFT on oe_q=1 and lat_q=0.
  - SHIFT -> COMMIT on a lat_q rising edge (lat_q=1 and the previous lat_q=0).
  - SHIFT -> IDLE on oe_q=0 with no latch. The count and shift register are kept, and a later latch still commits.
  - IDLE -> COMMIT on a lat_q rising edge.
  - COMMIT -> IDLE unconditionally, after one cycle.
- Sample condition: oe_q=1 and lat_q=0, in IDLE or SHIFT.
  - On each sample the 6-bit {r0,g0,b0,r1,g1,b1} shifts into a COLS-entry line register.
  - sample_cnt (7 bits) increments on each sample and saturates at COLS.
  - If more than COLS samples arrive, the last COLS are kept. The oldest retained sample becomes column 0.
- Commit cycle (COMMIT state):
  - If sample_cnt = COLS: write the line register to frame-store entry addr_q, set the valid bit for that entry, pulse line_valid, and load line_row = addr_q.
  - If sample_cnt < COLS: no write, no line_valid; pulse short_err.
  - In both cases sample_cnt clears to 0.
  - frame_done pulses together with line_valid when addr_q = ROWPAIRS-1.
- Address: the row-pair address is sampled from addr_q in the commit cycle, not at shift time.
- Read mapping:
  - rd_row < 16 returns upper-half bits from entry rd_row.
  - rd_row >= 16 returns lower-half bits from entry rd_row-16.
  - Column rd_col is selected within that entry.
- Boundary cases:
  - A latch with oe_q=0 still commits if sample_cnt = COLS.
  - Back-to-back latches: the second one sees sample_cnt=0 and raises short_err.
  - Rewriting a committed entry overwrites it silently.
  - Reading an entry in the same cycle it is written returns the old data.
- Reset mid-line: sample_cnt, FSM and all valid bits clear. Line register and frame-store data are not reset, but the cleared valid bits mask them to 0.

## Timing
- Reset values: rd_rgb 0, line_valid 0, line_row 0, frame_done 0, short_err 0.
- Pin-to-sample latency is 1 clk (input register).
- The LAT pin rising at cycle t gives COMMIT at t+2. line_valid, frame_done and short_err are high during t+2 only.
- The frame-store entry is readable from t+3.
- Read latency is 1 clk: rd_row/rd_col at cycle n gives rd_rgb at n+1, registered.
- The block sustains one sample per clk with no back-pressure.

## Structure
- Shared package hub75_pkg holds:
  - HUB75_COLS=64, HUB75_ROWPAIRS=16
  - the pixel6_t typedef {r0,g0,b0,r1,g1,b1}
  - FSM state constants
  - the driver's state encodings, reused by the bench
- Sub-module hub75_frame_store holds ROWPAIRS x (COLS*6)-bit storage:
  - one full-line write port
  - one registered 3-bit read port with upper/lower select
  - a ROWPAIRS-bit valid vector with asynchronous clear

## Test plan
- Reset then read (5,10) -> rd_rgb=0. All pulse outputs are 0 in the reset state.
- Address 3, OE high for 64 clk with column c driven as r0=c[0], g1=1, then LAT rising:
  - line_valid pulses 2 clk after the LAT rise, line_row=3.
  - Read (3,5) -> 3'b100; read (19,0) -> 3'b010.
- 65 samples where sample 0 = 6'b111111 and the rest are 0, then LAT -> committed line column 0 = 0, because the first sample is dropped.
- 40 samples then LAT -> short_err pulses once, no line_valid; read (row, any column) still returns 0.
- Full frame, addresses 0..15 each with 64 samples -> 16 line_valid pulses, frame_done only on address 15; reads match the driven pattern at all 2048 positions.
- Assert rst at sample 30 of address 7, then a full 64-sample line with LAT -> a clean commit with no short_err; a previously valid address 2 now reads 0.
